// File: rtl/pmp_pkg.sv
// Shared types and constants for the PMP relative-phase front end.
package pmp_pkg;

    localparam int unsigned PKT_CNT_W  = 16;
    localparam int unsigned PMP_BEAT_W = 128;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        CAPTURE
    } state_t;

    typedef struct packed {
        logic                  tlast;
        logic [PMP_BEAT_W-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/frame_packer_fifo.sv
// Synchronous first-word-fall-through FIFO with a registered output stage and
// a registered occupancy count (memory plus output register).
module frame_packer_fifo #(
    parameter int unsigned WIDTH = 129,
    parameter int unsigned DEPTH = 512
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   rd_valid,
    output logic [$clog2(DEPTH):0] occupancy
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      mem_cnt;
    logic             load_c;
    logic             pop_c;

    assign pop_c  = rd_valid && rd_en;
    assign load_c = (mem_cnt != '0) && (!rd_valid || rd_en);

    always_ff @(posedge aclk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    // Output register refills from memory whenever it is empty or being consumed.
    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            mem_cnt   <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            occupancy <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (load_c) begin
                rd_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + AW'(1);
            end
            if (load_c) rd_valid <= 1'b1;
            else if (pop_c) rd_valid <= 1'b0;
            mem_cnt   <= mem_cnt + (AW+1)'(wr_en) - (AW+1)'(load_c);
            occupancy <= occupancy + (AW+1)'(wr_en) - (AW+1)'(pop_c);
        end
    end

endmodule

// File: rtl/adc_frame_packer.sv
// Frames a free-running ADC beat stream into triggered AXI-Stream packets with tlast.
// Define FRAME_PACKER_TPG_EN to add the cfg_tpg ramp test-pattern input.
module adc_frame_packer
    import pmp_pkg::*;
#(
    parameter int unsigned BEAT_SIZE  = 8,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned PACKET_LEN = 128,
    parameter int unsigned FIFO_DEPTH = 512
) (
    input  logic                            aclk,
    input  logic                            areset,
    input  logic [BEAT_SIZE*DATA_WIDTH-1:0] adc_tdata,
    input  logic                            adc_tvalid,
    input  logic                            arm,
    input  logic                            trig,
    input  logic                            cfg_continuous,
`ifdef FRAME_PACKER_TPG_EN
    input  logic                            cfg_tpg,
`endif
    output logic [BEAT_SIZE*DATA_WIDTH-1:0] m_axis_tdata,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic                            m_axis_tlast,
    output logic                            busy,
    output logic                            ovf,
    output logic [PKT_CNT_W-1:0]            pkt_cnt
);
    localparam int unsigned BEAT_W  = BEAT_SIZE * DATA_WIDTH;
    localparam int unsigned ENTRY_W = BEAT_W + 1;
    localparam int unsigned CNT_W   = $clog2(PACKET_LEN);
    localparam int unsigned OCC_W   = $clog2(FIFO_DEPTH) + 1;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic               capture_c;
    logic               last_c;
    logic               full_c;
    logic               room_c;
    logic               wr_c;
    logic               drop_c;
    logic [BEAT_W-1:0]  beat_data_c;
    logic               stage_vld_q;
    logic [ENTRY_W-1:0] stage_q;
    logic [OCC_W-1:0]   fifo_occ;
    logic [OCC_W:0]     occ_c;
    logic [ENTRY_W-1:0] fifo_dout;
    logic               fifo_dvalid;

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // Beat 0 may coincide with trig; beat_cnt rests at 0 outside a capture.
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        capture_c  = 1'b0;
        last_c     = (beat_cnt_q == CNT_W'(PACKET_LEN - 1));
        case (state_q)
            IDLE:    if (arm) state_d = ARMED;
            ARMED: begin
                if (trig) begin
                    state_d   = CAPTURE;
                    capture_c = adc_tvalid;
                end
            end
            CAPTURE: capture_c = adc_tvalid;
            default: state_d = IDLE;
        endcase
        if (capture_c) begin
            if (last_c) begin
                beat_cnt_d = '0;
                state_d    = cfg_continuous ? ARMED : IDLE;
            end else begin
                beat_cnt_d = beat_cnt_q + CNT_W'(1);
            end
        end
    end

    // Occupancy includes the staged beat so the full decision is exact.
    // A last beat that finds even the reserve slot taken belongs to a packet
    // with no stored beats, so dropping it never leaves a packet open.
    assign occ_c  = {1'b0, fifo_occ} + (OCC_W+1)'(stage_vld_q);
    assign full_c = (occ_c >= (OCC_W+1)'(FIFO_DEPTH - 1));
    assign room_c = (occ_c <  (OCC_W+1)'(FIFO_DEPTH));
    assign wr_c   = capture_c && (last_c ? room_c : !full_c);
    assign drop_c = capture_c && !wr_c;

    always_comb begin
        beat_data_c = adc_tdata;
`ifdef FRAME_PACKER_TPG_EN
        if (cfg_tpg) begin
            for (int unsigned j = 0; j < BEAT_SIZE; j++) begin
                beat_data_c[j*DATA_WIDTH +: DATA_WIDTH] =
                    DATA_WIDTH'(32'(beat_cnt_q) * BEAT_SIZE + j);
            end
        end
`endif
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            stage_vld_q <= 1'b0;
            stage_q     <= '0;
            busy        <= 1'b0;
            ovf         <= 1'b0;
            pkt_cnt     <= '0;
        end else begin
            stage_vld_q <= wr_c;
            if (wr_c) stage_q <= {last_c, beat_data_c};
            busy <= (state_q != IDLE);
            if (drop_c) ovf <= 1'b1;
            else if (arm && (state_q != CAPTURE)) ovf <= 1'b0;
            if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
                pkt_cnt <= pkt_cnt + PKT_CNT_W'(1);
            end
        end
    end

    frame_packer_fifo #(
        .WIDTH(ENTRY_W),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .aclk     (aclk),
        .areset   (areset),
        .wr_en    (stage_vld_q),
        .wr_data  (stage_q),
        .rd_en    (m_axis_tready),
        .rd_data  (fifo_dout),
        .rd_valid (fifo_dvalid),
        .occupancy(fifo_occ)
    );

    assign m_axis_tdata  = fifo_dout[BEAT_W-1:0];
    assign m_axis_tlast  = fifo_dout[BEAT_W];
    assign m_axis_tvalid = fifo_dvalid;

endmodule

// File: tb/tb_adc_frame_packer.sv
// Bench for adc_frame_packer: directed sequence with randomized data and ready,
// outputs compared against expected-beat queues built from the framing rules.
`timescale 1ns/1ps
module tb_adc_frame_packer;
    localparam int unsigned BS     = 8;
    localparam int unsigned DW     = 16;
    localparam int unsigned PL     = 128;
    localparam int unsigned BW     = BS * DW;
    localparam int unsigned SDEPTH = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          areset;
    logic [BW-1:0] adc_tdata;
    logic          adc_tvalid, arm, trig, cfg_continuous;
`ifdef FRAME_PACKER_TPG_EN
    logic          cfg_tpg;
    logic [BW-1:0] out_log [PL];
`endif
    logic          tready, s_tready;
    logic [BW-1:0] tdata, s_tdata;
    logic          tvalid, tlast, busy, ovf;
    logic          s_tvalid, s_tlast, s_busy, s_ovf;
    logic [15:0]   pkt_cnt, s_pkt_cnt;

    int            n_checks = 0;
    int            n_errors = 0;
    bit            rand_ready = 1'b0;
    bit            log_en = 1'b0;
    int            log_idx;
    logic [BW:0]   exp_q[$];
    logic [BW:0]   exp_s_q[$];
    bit            hold_v, hold_s_v;
    logic [BW:0]   hold_e, hold_s_e;

    adc_frame_packer #(.BEAT_SIZE(BS), .DATA_WIDTH(DW), .PACKET_LEN(PL), .FIFO_DEPTH(512)) dut (
        .aclk(clk), .areset(areset), .adc_tdata(adc_tdata), .adc_tvalid(adc_tvalid),
        .arm(arm), .trig(trig), .cfg_continuous(cfg_continuous),
`ifdef FRAME_PACKER_TPG_EN
        .cfg_tpg(cfg_tpg),
`endif
        .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
        .m_axis_tlast(tlast), .busy(busy), .ovf(ovf), .pkt_cnt(pkt_cnt));

    adc_frame_packer #(.BEAT_SIZE(BS), .DATA_WIDTH(DW), .PACKET_LEN(PL), .FIFO_DEPTH(SDEPTH)) dut_s (
        .aclk(clk), .areset(areset), .adc_tdata(adc_tdata), .adc_tvalid(adc_tvalid),
        .arm(arm), .trig(trig), .cfg_continuous(cfg_continuous),
`ifdef FRAME_PACKER_TPG_EN
        .cfg_tpg(cfg_tpg),
`endif
        .m_axis_tdata(s_tdata), .m_axis_tvalid(s_tvalid), .m_axis_tready(s_tready),
        .m_axis_tlast(s_tlast), .busy(s_busy), .ovf(s_ovf), .pkt_cnt(s_pkt_cnt));

    task automatic check(input string tag, input logic [BW:0] obs, input logic [BW:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [BW-1:0] ramp(input int b);
        logic [BW-1:0] r;
        for (int j = 0; j < BS; j++) r[j*DW +: DW] = DW'(b * BS + j);
        return r;
    endfunction

    function automatic logic [BW-1:0] rand_beat();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Large instance: ordered delivery, AXIS hold rules, optional beat log.
    always @(negedge clk) begin
        if (areset) begin
            hold_v  <= 1'b0;
            log_idx <= 0;
        end else begin
            if (hold_v) begin
                check("hold_tvalid", tvalid, 1'b1);
                check("hold_beat", {tlast, tdata}, hold_e);
            end
            if (tvalid && tready) begin
                check("unexpected_beat", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    check("beat", {tlast, tdata}, exp_q[0]);
                    void'(exp_q.pop_front());
                end
`ifdef FRAME_PACKER_TPG_EN
                if (log_en && log_idx < PL) begin
                    out_log[log_idx] <= tdata;
                    log_idx <= log_idx + 1;
                end
`endif
            end
            hold_v <= tvalid && !tready;
            hold_e <= {tlast, tdata};
        end
    end

    // Small-FIFO instance: same checks against its own queue.
    always @(negedge clk) begin
        if (areset) begin
            hold_s_v <= 1'b0;
        end else begin
            if (hold_s_v) begin
                check("s_hold_tvalid", s_tvalid, 1'b1);
                check("s_hold_beat", {s_tlast, s_tdata}, hold_s_e);
            end
            if (s_tvalid && s_tready) begin
                check("s_unexpected_beat", exp_s_q.size() != 0, 1'b1);
                if (exp_s_q.size() != 0) begin
                    check("s_beat", {s_tlast, s_tdata}, exp_s_q[0]);
                    void'(exp_s_q.pop_front());
                end
            end
            hold_s_v <= s_tvalid && !s_tready;
            hold_s_e <= {s_tlast, s_tdata};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) tready = 1'($urandom_range(1));
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic do_reset();
        areset = 1'b1;
        rand_ready = 1'b0;
        tick();
        tick();
        exp_q.delete();
        exp_s_q.delete();
        areset = 1'b0;
        tick();
    endtask

    task automatic stray_beats(input int n);
        for (int i = 0; i < n; i++) begin
            adc_tdata  = rand_beat();
            adc_tvalid = 1'b1;
            tick();
        end
        adc_tvalid = 1'b0;
    endtask

    // Trig on the first cycle; beat 0 is the first valid beat at or after it.
    task automatic send_packet(input bit rnd, input logic [DW-1:0] pat, input int n,
                               input int gap_pct, input bit push, input bit push_s,
                               input bit tpg);
        logic [BW-1:0] d;
        for (int b = 0; b < n; b++) begin
            if (b == 0) trig = 1'b1;
            while (int'($urandom_range(99)) < gap_pct) begin
                adc_tvalid = 1'b0;
                tick();
                trig = 1'b0;
            end
            d = rnd ? rand_beat() : {BS{pat}};
            adc_tdata  = d;
            adc_tvalid = 1'b1;
            if (rnd && b == PL / 2) trig = 1'b1;
            if (push) exp_q.push_back({b == PL - 1, tpg ? ramp(b) : d});
            if (push_s && (b < SDEPTH - 1 || b == PL - 1)) exp_s_q.push_back({b == PL - 1, d});
            tick();
            trig = 1'b0;
        end
        adc_tvalid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || exp_s_q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        check("drain_left", exp_q.size() + exp_s_q.size(), 0);
        repeat (3) tick();
    endtask

    initial begin
        logic [DW-1:0] pats [3];
        pats[0] = 16'h0001;
        pats[1] = 16'h00FF;
        pats[2] = 16'h0080;
        areset = 1'b1; adc_tdata = '0; adc_tvalid = 1'b0; arm = 1'b0; trig = 1'b0;
        cfg_continuous = 1'b0; tready = 1'b0; s_tready = 1'b0;
`ifdef FRAME_PACKER_TPG_EN
        cfg_tpg = 1'b0;
`endif
        repeat (3) tick();
        areset = 1'b0;
        tick();
        check("rst_tvalid", tvalid, 0);
        check("rst_tlast", tlast, 0);
        check("rst_tdata", tdata, 0);
        check("rst_busy", busy, 0);
        check("rst_ovf", ovf, 0);
        check("rst_pkt_cnt", pkt_cnt, 0);

        // Single packet of constant data, sink always ready.
        tready = 1'b1;
        pulse_arm();
        repeat (2) tick();
        check("t1_busy_armed", busy, 1);
        send_packet(1'b0, 16'h00FF, PL, 0, 1'b1, 1'b0, 1'b0);
        drain(400);
        check("t1_pkt_cnt", pkt_cnt, 1);
        check("t1_ovf", ovf, 0);
        check("t1_busy_idle", busy, 0);

        // Trig while idle is ignored.
        trig = 1'b1;
        tick();
        trig = 1'b0;
        stray_beats(200);
        repeat (10) tick();
        check("t2_busy", busy, 0);
        check("t2_tvalid", tvalid, 0);
        check("t2_pkt_cnt", pkt_cnt, 1);

        // Continuous mode: one arm, three triggers, stray beats in ARMED ignored.
        do_reset();
        cfg_continuous = 1'b1;
        pulse_arm();
        for (int p = 0; p < 3; p++) begin
            stray_beats(5);
            send_packet(1'b0, pats[p], PL, 10, 1'b1, 1'b0, 1'b0);
            repeat (3) tick();
            check("t3_busy", busy, 1);
        end
        drain(600);
        check("t3_pkt_cnt", pkt_cnt, 3);
        check("t3_busy_end", busy, 1);
        cfg_continuous = 1'b0;

        // Overflow on the 16-deep instance with its sink stalled.
        do_reset();
        pulse_arm();
        tick();
        send_packet(1'b1, '0, PL, 0, 1'b1, 1'b1, 1'b0);
        repeat (20) tick();
        check("t4_s_ovf", s_ovf, 1);
        check("t4_s_busy", s_busy, 0);
        check("t4_s_tvalid", s_tvalid, 1);
        check("t4_ovf_big", ovf, 0);
        s_tready = 1'b1;
        drain(400);
        check("t4_s_pkt_cnt", s_pkt_cnt, 1);
        check("t4_pkt_cnt", pkt_cnt, 1);
        pulse_arm();
        repeat (2) tick();
        check("t4_s_ovf_cleared", s_ovf, 0);
        s_tready = 1'b0;

        // Random backpressure and input gaps over four packets.
        do_reset();
        rand_ready = 1'b1;
        for (int p = 0; p < 4; p++) begin
            pulse_arm();
            repeat (2) tick();
            send_packet(1'b1, '0, PL, 25, 1'b1, 1'b0, 1'b0);
        end
        drain(3000);
        rand_ready = 1'b0;
        tready = 1'b1;
        check("t5_pkt_cnt", pkt_cnt, 4);
        check("t5_ovf", ovf, 0);

        // Reset in the middle of a capture, then a clean packet.
        do_reset();
        tready = 1'b0;
        pulse_arm();
        tick();
        send_packet(1'b1, '0, 60, 0, 1'b0, 1'b0, 1'b0);
        areset = 1'b1;
        adc_tdata = rand_beat();
        adc_tvalid = 1'b1;
        tick();
        check("t6_tvalid", tvalid, 0);
        check("t6_tlast", tlast, 0);
        check("t6_tdata", tdata, 0);
        check("t6_busy", busy, 0);
        check("t6_ovf", ovf, 0);
        check("t6_pkt_cnt", pkt_cnt, 0);
        areset = 1'b0;
        adc_tvalid = 1'b0;
        tready = 1'b1;
        tick();
`ifdef FRAME_PACKER_TPG_EN
        cfg_tpg = 1'b1;
        log_en = 1'b1;
        pulse_arm();
        tick();
        send_packet(1'b1, '0, PL, 0, 1'b1, 1'b0, 1'b1);
`else
        pulse_arm();
        tick();
        send_packet(1'b1, '0, PL, 0, 1'b1, 1'b0, 1'b0);
`endif
        drain(400);
        check("t6_pkt_cnt_after", pkt_cnt, 1);
`ifdef FRAME_PACKER_TPG_EN
        check("t6_tpg_b1_s0", out_log[1][DW-1:0], 8);
        check("t6_tpg_b127_s7", out_log[PL-1][BW-1 -: DW], 1023);
        cfg_tpg = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within 500000 ns");
        $fatal(1, "watchdog expired");
    end

endmodule
